// File: rtl/pbuf2pe.sv
// Read-side sequencer for the 4-bank parameter buffer and the bias buffer.
// Reads one bias word, then replays a pbuf address range to the PE array through a 2-entry skid FIFO.
module pbuf2pe #(
  parameter int BUF_DEPTH = 256,
  parameter int ADDR_W    = $clog2(BUF_DEPTH),
  parameter int DATA_W    = 16,
  parameter int BATCH     = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_start,
  output logic                               o_busy,
  output logic                               o_done,
  input  logic [ADDR_W-1:0]                  i_rd_base,
  input  logic [ADDR_W:0]                    i_rd_len,
  input  logic [3:0]                         i_rep_num,
  input  logic [ADDR_W-1:0]                  i_bias_addr,
  output logic [3:0]                         o_pbuf_rd_en,
  output logic [3:0][ADDR_W-1:0]             o_pbuf_rd_addr,
  input  logic [3:0][DATA_W*BATCH-1:0]       i_pbuf_rd_data,
  output logic                               o_bbuf_rd_en,
  output logic [ADDR_W-1:0]                  o_bbuf_rd_addr,
  input  logic [DATA_W-1:0]                  i_bbuf_rd_data,
  output logic [3:0][DATA_W*BATCH-1:0]       o_out_data,
  output logic                               o_out_valid,
  input  logic                               i_out_ready,
  output logic                               o_out_last,
  output logic [DATA_W-1:0]                  o_bias_out,
  output logic                               o_bias_valid
);

  localparam int WORD_W = DATA_W * BATCH;
  localparam logic [ADDR_W:0] LEN_ONE = 1;

  typedef logic [3:0][WORD_W-1:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_BIAS, S_RUN, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [3:0]        r_rep;
  logic [ADDR_W-1:0] r_bias_addr;
  logic [ADDR_W:0]   r_idx;
  logic [3:0]        r_pass;

  logic              r_inflight;
  logic              r_infl_last;
  logic              r_bias_pend;
  logic [DATA_W-1:0] r_bias_out;
  logic              r_bias_valid;
  logic              r_done;

  word_t             r_fifo_data [2];
  logic [1:0]        r_fifo_last;
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_cnt;

  logic              w_pop;
  logic              w_room;
  logic              w_start_ok;
  logic              w_word_last;
  logic              w_pass_last;
  logic [1:0]        w_cnt_next;
  logic [ADDR_W-1:0] w_addr;
  logic              w_issue;
  logic              w_bbuf_en;
  logic              w_done_next;

  assign w_pop       = o_out_valid && i_out_ready;
  assign w_start_ok  = (r_state == S_IDLE) && i_start && !r_done;
  assign w_word_last = (r_idx == (r_len - LEN_ONE));
  assign w_pass_last = (r_pass == r_rep);
  assign w_cnt_next  = r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_addr      = r_base + r_idx[ADDR_W-1:0];

  // A read issued now lands in the FIFO two cycles later; count it against the space it will need.
  assign w_room = (({1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop}) < 3'd2);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_bbuf_en    = 1'b0;
    w_done_next  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_next = S_BIAS;
      end
      S_BIAS: begin
        w_bbuf_en    = 1'b1;
        w_state_next = (r_len == '0) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (w_room) begin
          w_issue = 1'b1;
          if (w_word_last && w_pass_last) w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!r_inflight && (w_cnt_next == 2'd0)) begin
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_base       <= '0;
      r_len        <= '0;
      r_rep        <= '0;
      r_bias_addr  <= '0;
      r_idx        <= '0;
      r_pass       <= '0;
      r_inflight   <= 1'b0;
      r_infl_last  <= 1'b0;
      r_bias_pend  <= 1'b0;
      r_bias_out   <= '0;
      r_bias_valid <= 1'b0;
      r_done       <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_cnt        <= '0;
      r_fifo_last  <= '0;
      // NOTE: the two skid entries are reset too, so out_data reads zero rather than stale data after reset.
      for (int e = 0; e < 2; e++) r_fifo_data[e] <= '0;
    end else begin
      r_done      <= w_done_next;
      r_bias_pend <= w_bbuf_en;
      r_inflight  <= w_issue;
      r_cnt       <= w_cnt_next;

      if (w_start_ok) begin
        r_base       <= i_rd_base;
        r_len        <= i_rd_len;
        r_rep        <= i_rep_num;
        r_bias_addr  <= i_bias_addr;
        r_idx        <= '0;
        r_pass       <= '0;
        r_bias_valid <= 1'b0;
      end

      if (r_bias_pend) begin
        r_bias_out   <= i_bbuf_rd_data;
        r_bias_valid <= 1'b1;
      end

      if (w_issue) begin
        r_infl_last <= w_word_last;
        if (w_word_last) begin
          r_idx  <= '0;
          r_pass <= r_pass + 4'd1;
        end else begin
          r_idx  <= r_idx + LEN_ONE;
        end
      end

      if (w_pop) r_rd_ptr <= ~r_rd_ptr;

      if (r_inflight) begin
        r_fifo_data[r_wr_ptr] <= i_pbuf_rd_data;
        r_fifo_last[r_wr_ptr] <= r_infl_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
    end
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = r_done;
  assign o_pbuf_rd_en   = {4{w_issue}};
  assign o_pbuf_rd_addr = {4{w_addr}};
  assign o_bbuf_rd_en   = w_bbuf_en;
  assign o_bbuf_rd_addr = r_bias_addr;
  assign o_out_data     = r_fifo_data[r_rd_ptr];
  assign o_out_valid    = (r_cnt != 2'd0);
  assign o_out_last     = r_fifo_last[r_rd_ptr];
  assign o_bias_out     = r_bias_out;
  assign o_bias_valid   = r_bias_valid;

endmodule
